// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg
//   Shared types and constants for the unified-memory port arbiter.
//   - arb_state_t : transaction FSM states (idle, memory access, response)
//   - OWN_I/OWN_D : encoding of which processor port owns a transaction
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_RESP
    } arb_state_t;

    localparam logic OWN_I = 1'b0;
    localparam logic OWN_D = 1'b1;

endpackage

// File: rtl/mem_arb_pick.sv
// mem_arb_pick
//   Combinational winner select between the instruction-fetch port and the
//   data port. A lone requester always wins. On a tie the data port wins,
//   unless the round-robin build is selected.
//   Configuration macro: MEM_ARB_RR_EN (defined = round-robin tie break,
//   the tie goes to the port that did not own the previous grant).
// Ports
//   i_req      in   fetch port request
//   d_req      in   data port request
//   last_owner in   owner of the most recent grant (OWN_I / OWN_D)
//   grant      out  1 when any port is requesting
//   owner      out  winning port (OWN_I / OWN_D), meaningful when grant=1
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic i_req,
    input  logic d_req,
    input  logic last_owner,
    output logic grant,
    output logic owner
);

`ifdef MEM_ARB_RR_EN
    logic tie_owner;
    assign tie_owner = (last_owner == OWN_I) ? OWN_D : OWN_I;
`else
    // Fixed priority never looks at history; the fetch port can starve.
    logic tie_owner;
    logic unused_last_owner;
    assign tie_owner         = OWN_D;
    assign unused_last_owner = last_owner;
`endif

    always_comb begin
        grant = i_req | d_req;
        owner = OWN_I;
        if (i_req && d_req) begin
            owner = tie_owner;
        end else if (d_req) begin
            owner = OWN_D;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-port memory between the processor's instruction-fetch
//   port (I) and data port (D). Each transaction takes three cycles:
//   IDLE (grant + latch) -> ACCESS (drive memory, capture read data) ->
//   RESP (one-cycle ack to the owner). No pipelining.
//   Configuration macro: MEM_ARB_RR_EN (see mem_arb_pick) selects round-robin
//   instead of fixed D-over-I priority.
// Ports
//   clk, rst           clock, synchronous active-high reset
//   i_req/i_addr       fetch request and word address
//   i_ack/i_rdata      fetch done pulse and registered instruction
//   d_req/d_we/d_addr/d_wdata  data request, write flag, address, write data
//   d_ack/d_rdata      data done pulse and registered read data
//   m_w/m_addr/m_wdata memory write enable, address, write data
//   m_rdata            memory read data (combinational from m_addr)
//   busy               1 whenever a transaction is in flight
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic          i_ack,
    output logic [DW-1:0] i_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_ack,
    output logic [DW-1:0] d_rdata,
    output logic          m_w,
    output logic [AW-1:0] m_addr,
    output logic [DW-1:0] m_wdata,
    input  logic [DW-1:0] m_rdata,
    output logic          busy
);

    arb_state_t    state, state_next;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    logic          we_q;
    logic          owner_q;
    logic          last_owner;
    logic          grant;
    logic          pick_owner;

    mem_arb_pick u_pick (
        .i_req      (i_req),
        .d_req      (d_req),
        .last_owner (last_owner),
        .grant      (grant),
        .owner      (pick_owner)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:   if (grant) state_next = ST_ACCESS;
            ST_ACCESS: state_next = ST_RESP;
            ST_RESP:   state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    // The winning request is captured once in IDLE so the memory side stays
    // stable even if a requester misbehaves and drops its request early.
    // A fetch keeps the previous write data; only its address is taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q     <= '0;
            wdata_q    <= '0;
            we_q       <= 1'b0;
            owner_q    <= OWN_I;
            last_owner <= OWN_I;
        end else if (state == ST_IDLE && grant) begin
            owner_q    <= pick_owner;
            last_owner <= pick_owner;
            if (pick_owner == OWN_D) begin
                addr_q  <= d_addr;
                we_q    <= d_we;
                wdata_q <= d_wdata;
            end else begin
                addr_q  <= i_addr;
                we_q    <= 1'b0;
            end
        end
    end

    // Read data is sampled at the end of ACCESS; a data write leaves
    // d_rdata holding whatever the last data read returned.
    always_ff @(posedge clk) begin
        if (rst) begin
            i_rdata <= '0;
            d_rdata <= '0;
        end else if (state == ST_ACCESS) begin
            if (owner_q == OWN_I) begin
                i_rdata <= m_rdata;
            end else if (!we_q) begin
                d_rdata <= m_rdata;
            end
        end
    end

    // rst gates the write strobe and acks combinationally so that a reset
    // landing on ACCESS or RESP neither writes memory nor completes.
    assign m_w     = (state == ST_ACCESS) && (owner_q == OWN_D) && we_q && !rst;
    assign i_ack   = (state == ST_RESP) && (owner_q == OWN_I) && !rst;
    assign d_ack   = (state == ST_RESP) && (owner_q == OWN_D) && !rst;
    assign m_addr  = addr_q;
    assign m_wdata = wdata_q;
    assign busy    = (state != ST_IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
//   Self-checking bench for mem_port_arbiter. A 64-word behavioural memory
//   sits on the m_* pins; a reference array plus a tiny grant model predict
//   ack timing, ack owner and returned data.
`timescale 1ns/1ps
module tb_mem_port_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int MW = 64;
    localparam logic PORT_I = 1'b0;
    localparam logic PORT_D = 1'b1;
`ifdef MEM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          i_req;
    logic [AW-1:0] i_addr;
    logic          i_ack;
    logic [DW-1:0] i_rdata;
    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          d_ack;
    logic [DW-1:0] d_rdata;
    logic          m_w;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic [DW-1:0] m_rdata;
    logic          busy;

    logic [DW-1:0] mem [0:MW-1];
    logic          pre_we;
    logic [5:0]    pre_addr;
    logic [DW-1:0] pre_data;

    logic [DW-1:0] ref_mem [0:MW-1];
    logic [DW-1:0] exp_i_rdata;
    logic [DW-1:0] exp_d_rdata;
    logic          model_last;
    int            checks;
    int            errors;

    mem_port_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk     (clk),
        .rst     (rst),
        .i_req   (i_req),
        .i_addr  (i_addr),
        .i_ack   (i_ack),
        .i_rdata (i_rdata),
        .d_req   (d_req),
        .d_we    (d_we),
        .d_addr  (d_addr),
        .d_wdata (d_wdata),
        .d_ack   (d_ack),
        .d_rdata (d_rdata),
        .m_w     (m_w),
        .m_addr  (m_addr),
        .m_wdata (m_wdata),
        .m_rdata (m_rdata),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    // Behavioural single-port memory with a preload port for the bench.
    always @(posedge clk) begin
        if (pre_we) begin
            mem[pre_addr] <= pre_data;
        end else if (m_w) begin
            mem[m_addr[5:0]] <= m_wdata;
        end
    end
    assign m_rdata = mem[m_addr[5:0]];

    // Grant rule: D wins ties, or alternate away from the last owner.
    function automatic logic pick_model(input logic last);
        return RR ? ~last : PORT_D;
    endfunction

    task automatic preload(input int a, input logic [DW-1:0] v);
        @(negedge clk);
        pre_we   = 1'b1;
        pre_addr = a[5:0];
        pre_data = v;
        @(negedge clk);
        pre_we   = 1'b0;
        ref_mem[a] = v;
    endtask

    // One isolated transaction from IDLE; expects ack exactly 2 cycles later.
    task automatic run_single(input logic is_d, input logic we, input logic [AW-1:0] addr,
                              input logic [DW-1:0] wdata, input string name);
        int            cyc;
        logic          seen;
        logic          wr;
        logic [DW-1:0] exp_data;
        cyc = 0;
        seen = 1'b0;
        wr = is_d & we;
        if (is_d) begin
            d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata;
        end else begin
            i_req = 1'b1; i_addr = addr;
        end
        exp_data = ref_mem[addr[5:0]];
        if (wr) ref_mem[addr[5:0]] = wdata;
        if (is_d && !we) exp_d_rdata = exp_data;
        if (!is_d) exp_i_rdata = exp_data;
        while (!seen && cyc < 8) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin
                checks++;
                if (m_w !== wr || m_addr !== addr || busy !== 1'b1) begin
                    errors++;
                    $display("[TB] FAIL %s_access: m_w=%b m_addr=%h busy=%b, expected m_w=%b m_addr=%h busy=1",
                             name, m_w, m_addr, busy, wr, addr);
                end
                if (wr) begin
                    checks++;
                    if (m_wdata !== wdata) begin
                        errors++;
                        $display("[TB] FAIL %s_wdata: got %h expected %h", name, m_wdata, wdata);
                    end
                end
            end
            if ((is_d ? d_ack : i_ack) === 1'b1) seen = 1'b1;
        end
        checks++;
        if (!seen || cyc != 2) begin
            errors++;
            $display("[TB] FAIL %s_latency: ack seen=%b after %0d cycles, expected ack after 2", name, seen, cyc);
        end
        checks++;
        if ((is_d ? i_ack : d_ack) !== 1'b0 || m_w !== 1'b0) begin
            errors++;
            $display("[TB] FAIL %s_resp: other_ack=%b m_w=%b, expected 0 0", name, is_d ? i_ack : d_ack, m_w);
        end
        checks++;
        if (i_rdata !== exp_i_rdata || d_rdata !== exp_d_rdata) begin
            errors++;
            $display("[TB] FAIL %s_rdata: i_rdata=%h d_rdata=%h, expected %h %h",
                     name, i_rdata, d_rdata, exp_i_rdata, exp_d_rdata);
        end
        model_last = is_d;
        i_req = 1'b0;
        d_req = 1'b0;
        @(negedge clk);
        checks++;
        if (i_ack !== 1'b0 || d_ack !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL %s_idle: i_ack=%b d_ack=%b busy=%b, expected 0 0 0", name, i_ack, d_ack, busy);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int a = 0; a < MW; a++) preload(a, $urandom);
        repeat (2) @(negedge clk);
        checks++;
        if ({i_ack, d_ack, m_w, busy} !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL reset_ctrl: i_ack,d_ack,m_w,busy=%b expected 0000", {i_ack, d_ack, m_w, busy});
        end
        checks++;
        if (m_addr !== '0 || m_wdata !== '0) begin
            errors++;
            $display("[TB] FAIL reset_mem_pins: m_addr=%h m_wdata=%h expected 0 0", m_addr, m_wdata);
        end
        checks++;
        if (i_rdata !== '0 || d_rdata !== '0) begin
            errors++;
            $display("[TB] FAIL reset_rdata: i_rdata=%h d_rdata=%h expected 0 0", i_rdata, d_rdata);
        end
        rst = 1'b0;
        exp_i_rdata = '0;
        exp_d_rdata = '0;
        model_last  = PORT_I;
        repeat (4) begin
            @(negedge clk);
            checks++;
            if (busy !== 1'b0 || m_w !== 1'b0) begin
                errors++;
                $display("[TB] FAIL reset_quiet: busy=%b m_w=%b expected 0 0", busy, m_w);
            end
        end
    endtask

    task automatic test_i_fetch();
        preload(4, 32'h00A1_0020);
        run_single(PORT_I, 1'b0, 32'h4, '0, "i_fetch");
        checks++;
        if (i_rdata !== 32'h00A1_0020) begin
            errors++;
            $display("[TB] FAIL i_fetch_value: got %h expected 00a10020", i_rdata);
        end
    endtask

    task automatic test_d_write_read();
        run_single(PORT_D, 1'b1, 32'h10, 32'hDEAD_BEEF, "d_write");
        run_single(PORT_D, 1'b0, 32'h10, '0, "d_read");
        checks++;
        if (d_rdata !== 32'hDEAD_BEEF) begin
            errors++;
            $display("[TB] FAIL d_read_value: got %h expected deadbeef", d_rdata);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 20; n++) begin
            logic is_d;
            logic we;
            is_d = 1'($urandom_range(0, 1));
            we   = is_d & 1'($urandom_range(0, 1));
            run_single(is_d, we, $urandom, $urandom, "random");
        end
    endtask

    // Both ports request in the same IDLE cycle; each drops after its ack.
    task automatic test_tie();
        int            cyc;
        int            i_cyc;
        int            d_cyc;
        logic          first;
        logic [AW-1:0] ia;
        logic [AW-1:0] da;
        logic [DW-1:0] ei;
        logic [DW-1:0] ed;
        ia = $urandom;
        da = $urandom;
        ei = ref_mem[ia[5:0]];
        ed = ref_mem[da[5:0]];
        first = pick_model(model_last);
        i_req = 1'b1; i_addr = ia;
        d_req = 1'b1; d_we = 1'b0; d_addr = da;
        cyc = 0; i_cyc = 0; d_cyc = 0;
        while ((i_cyc == 0 || d_cyc == 0) && cyc < 15) begin
            @(negedge clk);
            cyc++;
            checks++;
            if (i_ack === 1'b1 && d_ack === 1'b1) begin
                errors++;
                $display("[TB] FAIL tie_both_ack: both acks high at cycle %0d, expected at most one", cyc);
            end
            if (i_ack === 1'b1 && i_cyc == 0) begin
                i_cyc = cyc;
                i_req = 1'b0;
                checks++;
                if (i_rdata !== ei) begin
                    errors++;
                    $display("[TB] FAIL tie_i_data: got %h expected %h", i_rdata, ei);
                end
            end
            if (d_ack === 1'b1 && d_cyc == 0) begin
                d_cyc = cyc;
                d_req = 1'b0;
                checks++;
                if (d_rdata !== ed) begin
                    errors++;
                    $display("[TB] FAIL tie_d_data: got %h expected %h", d_rdata, ed);
                end
            end
        end
        checks++;
        if (i_cyc != (first == PORT_D ? 5 : 2) || d_cyc != (first == PORT_D ? 2 : 5)) begin
            errors++;
            $display("[TB] FAIL tie_order: i_ack at %0d d_ack at %0d, expected %0d %0d",
                     i_cyc, d_cyc, first == PORT_D ? 5 : 2, first == PORT_D ? 2 : 5);
        end
        i_req = 1'b0;
        d_req = 1'b0;
        exp_i_rdata = ei;
        exp_d_rdata = ed;
        model_last  = ~first;
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        logic [DW-1:0] old;
        int            bad;
        old = ref_mem[32];
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h20; d_wdata = ~old;
        @(negedge clk);
        checks++;
        if (busy !== 1'b1 || m_w !== 1'b1) begin
            errors++;
            $display("[TB] FAIL rstmid_access: busy=%b m_w=%b expected 1 1", busy, m_w);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (m_w !== 1'b0) begin
            errors++;
            $display("[TB] FAIL rstmid_mw: got %b expected 0 while reset asserted", m_w);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || d_ack !== 1'b0 || i_ack !== 1'b0) begin
            errors++;
            $display("[TB] FAIL rstmid_state: busy=%b d_ack=%b i_ack=%b expected 0 0 0", busy, d_ack, i_ack);
        end
        rst = 1'b0;
        d_req = 1'b0;
        exp_i_rdata = '0;
        exp_d_rdata = '0;
        model_last  = PORT_I;
        bad = 0;
        repeat (3) begin
            @(negedge clk);
            if (d_ack !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("[TB] FAIL rstmid_noack: d_ack seen %0d times expected 0", bad);
        end
        checks++;
        if (mem[32] !== old) begin
            errors++;
            $display("[TB] FAIL rstmid_mem: mem[0x20]=%h expected %h", mem[32], old);
        end
        run_single(PORT_D, 1'b0, 32'h20, '0, "rstmid_readback");
    endtask

    // D requests continuously while I holds its request; each acked port
    // immediately presents a new address.
    task automatic test_starvation();
        int   cyc;
        int   acks;
        int   last_ack_cyc;
        int   first_i_slot;
        int   exp_first_i;
        logic w;
        exp_first_i = RR ? ((model_last == PORT_I) ? 2 : 1) : 0;
        i_req = 1'b1; i_addr = $urandom;
        d_req = 1'b1; d_we = 1'b0; d_addr = $urandom;
        cyc = 0; acks = 0; last_ack_cyc = 0; first_i_slot = 0;
        while (acks < 10 && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (i_ack === 1'b1 || d_ack === 1'b1) begin
                acks++;
                w = pick_model(model_last);
                checks++;
                if (i_ack !== ~w || d_ack !== w) begin
                    errors++;
                    $display("[TB] FAIL starve_owner slot %0d: i_ack=%b d_ack=%b expected %b %b",
                             acks, i_ack, d_ack, ~w, w);
                end
                checks++;
                if (cyc - last_ack_cyc != (acks == 1 ? 2 : 3)) begin
                    errors++;
                    $display("[TB] FAIL starve_spacing slot %0d: gap %0d expected %0d",
                             acks, cyc - last_ack_cyc, acks == 1 ? 2 : 3);
                end
                checks++;
                if (d_ack === 1'b1) begin
                    if (d_rdata !== ref_mem[d_addr[5:0]]) begin
                        errors++;
                        $display("[TB] FAIL starve_d_data: got %h expected %h", d_rdata, ref_mem[d_addr[5:0]]);
                    end
                    exp_d_rdata = ref_mem[d_addr[5:0]];
                    d_addr = $urandom;
                end else begin
                    if (i_rdata !== ref_mem[i_addr[5:0]]) begin
                        errors++;
                        $display("[TB] FAIL starve_i_data: got %h expected %h", i_rdata, ref_mem[i_addr[5:0]]);
                    end
                    exp_i_rdata = ref_mem[i_addr[5:0]];
                    if (first_i_slot == 0) first_i_slot = acks;
                    i_addr = $urandom;
                end
                model_last = w;
                last_ack_cyc = cyc;
            end
        end
        checks++;
        if (acks != 10) begin
            errors++;
            $display("[TB] FAIL starve_timeout: %0d acks in %0d cycles expected 10", acks, cyc);
        end
        checks++;
        if (first_i_slot != exp_first_i) begin
            errors++;
            $display("[TB] FAIL starve_i_slot: first I ack at slot %0d expected %0d (0 = never)",
                     first_i_slot, exp_first_i);
        end
        i_req = 1'b0;
        d_req = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        rst     = 1'b1;
        i_req   = 1'b0;
        i_addr  = '0;
        d_req   = 1'b0;
        d_we    = 1'b0;
        d_addr  = '0;
        d_wdata = '0;
        pre_we  = 1'b0;
        pre_addr = '0;
        pre_data = '0;
        model_last  = PORT_I;
        exp_i_rdata = '0;
        exp_d_rdata = '0;
        test_reset();
        test_i_fetch();
        test_d_write_read();
        test_random();
        for (int n = 0; n < 3; n++) test_tie();
        test_reset_mid();
        test_starvation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
